// File: rtl/exp_client.sv
// Initiator for the iterative exponential engine: queues operands in a small FIFO,
// runs one engine transaction per operand and returns the result (or a timeout) downstream.
module exp_client #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  output logic        eng_rst,
  output logic        eng_start,
  output logic [15:0] eng_x,
  input  logic        eng_done,
  input  logic [1:0]  eng_intpart,
  input  logic [15:0] eng_fracpart,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_int,
  output logic [15:0] out_frac,
  output logic        out_err
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [15:0] TMAX    = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ERST  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   tcnt_q, tcnt_d;
  logic          eng_start_q, eng_start_d;
  logic [15:0]   eng_x_q, eng_x_d;
  logic          out_valid_q, out_valid_d;
  logic [1:0]    out_int_q, out_int_d;
  logic [15:0]   out_frac_q, out_frac_d;
  logic          out_err_q, out_err_d;
  logic          push;
  logic          pop;

  // Both ports use valid/ready: a transfer happens on a rising edge where valid and
  // ready are both high; a valid source holds its data unchanged until that edge.
  assign in_ready  = (count_q < DEPTH_C);
  assign push      = in_valid & in_ready;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);

  assign eng_rst   = rst | (state_q == S_ERST);
  assign eng_start = eng_start_q;
  assign eng_x     = eng_x_q;
  assign out_valid = out_valid_q;
  assign out_int   = out_int_q;
  assign out_frac  = out_frac_q;
  assign out_err   = out_err_q;

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    tcnt_d      = tcnt_q;
    eng_start_d = 1'b0;
    eng_x_d     = eng_x_q;
    out_valid_d = out_valid_q;
    out_int_d   = out_int_q;
    out_frac_d  = out_frac_q;
    out_err_d   = out_err_q;

    if (push) begin
      mem_d[wr_ptr_q] = in_x;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          eng_x_d = mem_q[rd_ptr_q];
          state_d = S_ERST;
        end
      end
      S_ERST: begin
        eng_start_d = 1'b1;
        state_d     = S_START;
      end
      S_START: begin
        tcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving in the last allowed cycle still counts as a real result.
        if (eng_done) begin
          out_int_d   = eng_intpart;
          out_frac_d  = eng_fracpart;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else if (tcnt_q == TMAX) begin
          out_int_d   = '0;
          out_frac_d  = '0;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tcnt_q      <= '0;
      eng_start_q <= 1'b0;
      eng_x_q     <= '0;
      out_valid_q <= 1'b0;
      out_int_q   <= '0;
      out_frac_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tcnt_q      <= tcnt_d;
      eng_start_q <= eng_start_d;
      eng_x_q     <= eng_x_d;
      out_valid_q <= out_valid_d;
      out_int_q   <= out_int_d;
      out_frac_q  <= out_frac_d;
      out_err_q   <= out_err_d;
    end
  end

endmodule

// File: tb/tb_exp_client.sv
// Bench for exp_client: engine model with programmable latency, cycle-level
// transaction model of the client, and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_exp_client;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_x = '0;
  logic        eng_done = 1'b0;
  logic [1:0]  eng_intpart = '0;
  logic [15:0] eng_fracpart = '0;
  logic        out_ready = 1'b1;
  logic        in_ready;
  logic        eng_rst;
  logic        eng_start;
  logic [15:0] eng_x;
  logic        out_valid;
  logic [1:0]  out_int;
  logic [15:0] out_frac;
  logic        out_err;

  exp_client #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .eng_rst(eng_rst), .eng_start(eng_start), .eng_x(eng_x),
    .eng_done(eng_done), .eng_intpart(eng_intpart), .eng_fracpart(eng_fracpart),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_int(out_int), .out_frac(out_frac), .out_err(out_err)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // engine model: eng_lat = 0 means it never answers
  int          eng_lat = 20;
  logic        force_done = 1'b0;
  bit          e_busy = 1'b0;
  int          e_cnt = 0;
  logic [15:0] e_x = '0;
  bit          e_hit;

  always begin
    @(posedge clk); #2;
    if (eng_rst) begin
      e_busy = 1'b0;
      e_cnt  = 0;
    end else if (eng_start) begin
      e_busy = 1'b1;
      e_cnt  = 0;
      e_x    = eng_x;
    end else if (e_busy) begin
      e_cnt++;
    end
    e_hit        = e_busy && !eng_start && (eng_lat != 0) && (e_cnt == eng_lat);
    eng_done     = e_hit || force_done;
    eng_intpart  = e_hit ? e_x[15:14] : 2'($urandom);
    eng_fracpart = e_hit ? ~e_x : 16'($urandom);
    if (e_hit) e_busy = 1'b0;
  end

  // scoreboard: exp_q holds operands accepted but not yet issued
  logic [15:0] exp_q[$];
  logic [1:0]  res_int_q[$];
  logic [15:0] res_frac_q[$];
  logic        res_err_q[$];
  int          cyc = 0;
  int          iss = 0;
  int          cur_lat = 0;
  int          lat_eff;
  logic [15:0] cur_x = '0;
  logic [15:0] cur_inv;
  bit          busy = 1'b0;
  bit          idle_prev = 1'b1;
  bit          nonempty_prev = 1'b0;
  bit          valid_prev = 1'b0;
  bit          exp_erst, exp_valid, timed_out;
  int          start_cyc = 0;
  int          valid_cyc = 0;
  int          start_cnt = 0;

  always begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      chk("eng_rst_during_reset", 32'(eng_rst), 32'd1);
      exp_q.delete();
      busy          = 1'b0;
      idle_prev     = 1'b1;
      nonempty_prev = 1'b0;
      valid_prev    = 1'b0;
    end else begin
      exp_erst = idle_prev && nonempty_prev;
      chk("eng_rst", 32'(eng_rst), 32'(exp_erst));
      if (exp_erst) begin
        cur_x   = exp_q.pop_front();
        busy    = 1'b1;
        iss     = cyc;
        cur_lat = eng_lat;
      end
      chk("eng_start", 32'(eng_start), 32'(busy && (cyc == iss + 1)));
      if (eng_start) begin
        start_cyc = cyc;
        start_cnt++;
      end
      if (busy) chk("eng_x", 32'(eng_x), 32'(cur_x));
      timed_out = (cur_lat == 0) || (cur_lat > TIMEOUT);
      lat_eff   = timed_out ? TIMEOUT : cur_lat;
      exp_valid = busy && (cyc >= iss + 2 + lat_eff);
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid) begin
        cur_inv = ~cur_x;
        chk("out_err", 32'(out_err), 32'(timed_out));
        chk("out_int", 32'(out_int), timed_out ? 32'd0 : 32'(cur_x[15:14]));
        chk("out_frac", 32'(out_frac), timed_out ? 32'd0 : 32'(cur_inv));
      end
      if (out_valid && !valid_prev) valid_cyc = cyc;
      valid_prev = out_valid;
      idle_prev  = !busy;
      if (exp_valid && out_ready) begin
        res_int_q.push_back(out_int);
        res_frac_q.push_back(out_frac);
        res_err_q.push_back(out_err);
        busy = 1'b0;
      end
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
      nonempty_prev = (exp_q.size() != 0);
      if (in_valid && (exp_q.size() < DEPTH)) exp_q.push_back(in_x);
    end
  end

  // driver tasks; all stimulus changes land 1ns after a rising edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push(input logic [15:0] x);
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_x     = x;
    for (int i = 0; i < 2000 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("push_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_result(input string name, input int bound, input logic [1:0] e_int,
                             input logic [15:0] e_frac, input logic e_err, input int e_lat);
    bit found;
    found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk); #1;
      found = out_valid;
    end
    if (found) begin
      chk({name, "_int"}, 32'(out_int), 32'(e_int));
      chk({name, "_frac"}, 32'(out_frac), 32'(e_frac));
      chk({name, "_err"}, 32'(out_err), 32'(e_err));
      chk({name, "_latency"}, 32'(valid_cyc - start_cyc), 32'(e_lat));
    end else begin
      chk({name, "_valid_timeout"}, 32'd0, 32'd1);
    end
    @(posedge clk); #1;
  endtask

  logic [15:0] ops   [5] = '{16'h0C10, 16'h1020, 16'h4000, 16'h8001, 16'hC0FF};
  logic [1:0]  ints  [5] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [15:0] fracs [5] = '{16'hF3EF, 16'hEFDF, 16'hBFFF, 16'h7FFE, 16'h3F00};

  initial begin
    int base;
    int sc;
    bit seen;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_eng_start", 32'(eng_start), 32'd0);
    chk("reset_eng_x", 32'(eng_x), 32'd0);
    chk("reset_out_fields", {13'd0, out_err, out_int, out_frac}, 32'd0);
    chk("reset_eng_rst", 32'(eng_rst), 32'd0);

    // single operand
    out_ready = 1'b1;
    push(16'h0010);
    wait_result("t1", 100, 2'd0, 16'hFFEF, 1'b0, 21);
    tick(3);

    // full FIFO, ordering and backpressure
    base = res_int_q.size();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) push(ops[k]);
    chk("t2_in_ready_full", 32'(in_ready), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick(1);
      seen = out_valid;
    end
    chk("t3_first_valid_seen", 32'(seen), 32'd1);
    sc = start_cnt;
    tick(50);
    chk("t3_hold_valid", 32'(out_valid), 32'd1);
    chk("t3_hold_frac", 32'(out_frac), 32'hF3EF);
    chk("t3_no_new_start", 32'(start_cnt - sc), 32'd0);
    chk("t3_still_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick(1);
    chk("t3_valid_drops", 32'(out_valid), 32'd0);
    tick(150);
    chk("t2_result_count", 32'(res_int_q.size() - base), 32'd5);
    if (res_int_q.size() >= base + 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("t2_order_int", 32'(res_int_q[base + k]), 32'(ints[k]));
        chk("t2_order_frac", 32'(res_frac_q[base + k]), 32'(fracs[k]));
        chk("t2_order_err", 32'(res_err_q[base + k]), 32'd0);
      end
    end

    // timeout, then a normal operand
    eng_lat = 0;
    push(16'h1234);
    wait_result("t4_timeout", 400, 2'd0, 16'h0000, 1'b1, 256);
    eng_lat = 20;
    push(16'h8000);
    wait_result("t4_next", 100, 2'd2, 16'h7FFF, 1'b0, 21);

    // done on the last allowed WAIT cycle
    eng_lat = 255;
    push(16'h5555);
    wait_result("t5_boundary", 400, 2'd1, 16'hAAAA, 1'b0, 256);
    eng_lat = 20;

    // reset in the middle of an operation with two operands queued
    push(16'h2222);
    push(16'h3333);
    push(16'h4444);
    tick(10);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    chk("t6_eng_start", 32'(eng_start), 32'd0);
    sc = start_cnt;
    tick(5);
    force_done = 1'b1;
    tick(1);
    force_done = 1'b0;
    tick(40);
    chk("t6_no_start", 32'(start_cnt - sc), 32'd0);
    chk("t6_late_done_ignored", 32'(out_valid), 32'd0);
    push(16'h0010);
    wait_result("t6_recover", 100, 2'd0, 16'hFFEF, 1'b0, 21);
    tick(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
